// File: rtl/mem_ftch_pkg.sv
// Shared types and constants for the memory-to-fetch packet queue.
// Used by mem_ftch_queue and mem_ftch_queue_ram (optional macro in the
// top: MEM_FTCH_QUEUE_BYPASS_EN).
package mem_ftch_pkg;

  // Default number of buffered packets (power of two, >= 2).
  localparam int MEM_FTCH_DEPTH_DEFAULT = 4;

  // Packet handed from the memory stage to the fetch stage.
  typedef struct packed {
    logic [7:0]  tag;   // request identifier
    logic [23:0] data;  // payload
  } mem_ftch_pkt_t;

  localparam int MEM_FTCH_PKT_W = $bits(mem_ftch_pkt_t);

endpackage

// File: rtl/mem_ftch_queue_ram.sv
// Packet storage for mem_ftch_queue: DEPTH x PKT_W, one synchronous write
// port and one asynchronous read port. Contents are never reset; the
// queue's pointers and count decide which entries are meaningful.
module mem_ftch_queue_ram
  import mem_ftch_pkg::*;
#(
  parameter int DEPTH = MEM_FTCH_DEPTH_DEFAULT,
  parameter int PKT_W = MEM_FTCH_PKT_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PKT_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PKT_W-1:0] rdata
);

  logic [PKT_W-1:0] mem [DEPTH];

  // Write port: store one packet when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read of the addressed entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ftch_queue.sv
// Memory-to-fetch packet queue: a DEPTH-entry FIFO with flush.
// Optional macro MEM_FTCH_QUEUE_BYPASS_EN: when the queue is empty, an
// incoming packet is presented to the consumer in the same cycle, and is
// not stored if the consumer takes it right away.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and mem_ftch_rdy depends only on
// registered state so there is no path from ftch_rdy to mem_ftch_rdy.
module mem_ftch_queue
  import mem_ftch_pkg::*;
#(
  parameter int DEPTH = MEM_FTCH_DEPTH_DEFAULT,
  parameter int PKT_W = $bits(mem_ftch_pkt_t)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       mem_ftch_vld,
  input  logic [PKT_W-1:0]           mem_ftch_pkt,
  output logic                       mem_ftch_rdy,
  output logic                       ftch_vld,
  output logic [PKT_W-1:0]           ftch_pkt,
  input  logic                       ftch_rdy,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             run_q;      // low in reset, high from the first edge after
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;      // packet actually written to storage
  logic             rd_en;      // stored head entry actually consumed
  logic             bypass;     // empty-queue pass-through this cycle
  logic [PKT_W-1:0] ram_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Ready comes purely from registers: held low through reset and until the
  // first edge after reset releases, then low only while full.
  assign mem_ftch_rdy = run_q && !full;

  assign push = mem_ftch_vld && mem_ftch_rdy;

`ifdef MEM_FTCH_QUEUE_BYPASS_EN
  // Pass-through is only offered for a packet that would be accepted anyway,
  // and never while a flush is discarding the queue.
  assign bypass   = empty && push && !flush;
  assign ftch_vld = !empty || bypass;
  assign ftch_pkt = bypass ? mem_ftch_pkt : ram_rdata;
`else
  assign bypass   = 1'b0;
  assign ftch_vld = !empty;
  assign ftch_pkt = ram_rdata;
`endif

  assign pop   = ftch_vld && ftch_rdy;
  // A bypassed packet taken by the consumer never touches storage.
  assign rd_en = pop && !empty;
  assign wr_en = push && !flush && !(bypass && ftch_rdy);

  // Occupancy update: +1 on store-only, -1 on consume-only, else hold.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and run-flag registers; flush clears all queue state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count_q <= count_d;
      end
    end
  end

  assign count = count_q;

  mem_ftch_queue_ram #(
    .DEPTH (DEPTH),
    .PKT_W (PKT_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (mem_ftch_pkt),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_ftch_queue.sv
// Self-checking bench for mem_ftch_queue: directed fill/drain/wrap/flush/
// reset steps followed by random traffic, all compared against a queue
// model of the expected FIFO contents.
module tb_mem_ftch_queue;
  import mem_ftch_pkg::*;

  localparam int DEPTH = 4;
  localparam int PKT_W = $bits(mem_ftch_pkt_t);
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef MEM_FTCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             mem_ftch_vld;
  logic [PKT_W-1:0] mem_ftch_pkt;
  logic             mem_ftch_rdy;
  logic             ftch_vld;
  logic [PKT_W-1:0] ftch_pkt;
  logic             ftch_rdy;
  logic             flush;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  // Reference model: packets expected to be buffered, oldest first.
  logic [PKT_W-1:0] exp_q[$];
  bit               rdy_ok;   // producer side expected to be open

  mem_ftch_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_ftch_vld (mem_ftch_vld),
    .mem_ftch_pkt (mem_ftch_pkt),
    .mem_ftch_rdy (mem_ftch_rdy),
    .ftch_vld     (ftch_vld),
    .ftch_pkt     (ftch_pkt),
    .ftch_rdy     (ftch_rdy),
    .flush        (flush),
    .count        (count)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [PKT_W-1:0] obs,
                           input logic [PKT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, take the
  // edge, then advance the model. Entered and left 1 time unit after posedge.
  task automatic cycle(input logic v, input logic [PKT_W-1:0] p,
                       input logic r, input logic f);
    int sz;
    bit byp;
    bit push;
    bit pop;
    mem_ftch_vld = v;
    mem_ftch_pkt = p;
    ftch_rdy     = r;
    flush        = f;
    #1;
    sz  = exp_q.size();
    byp = BYP && (sz == 0) && v && rdy_ok && !f;
    check_bit("ftch_vld", ftch_vld, (sz != 0) || byp);
    if (sz != 0) check_val("ftch_pkt", ftch_pkt, exp_q[0]);
    else if (byp) check_val("ftch_pkt_bypass", ftch_pkt, p);
    check_bit("mem_ftch_rdy", mem_ftch_rdy, rdy_ok && (sz != DEPTH));
    check_val("count", PKT_W'(count), PKT_W'(sz));
    @(posedge clk);
    if (resetn) begin
      if (f) begin
        exp_q.delete();
      end else begin
        push = v && rdy_ok && (sz != DEPTH);
        pop  = r && ((sz != 0) || byp);
        if (byp) begin
          if (!r) exp_q.push_back(p);
        end else begin
          if (pop) void'(exp_q.pop_front());
          if (push) exp_q.push_back(p);
        end
      end
      rdy_ok = 1'b1;
    end
    #1;
  endtask

  initial begin
    resetn       = 1'b0;
    mem_ftch_vld = 1'b0;
    mem_ftch_pkt = '0;
    ftch_rdy     = 1'b0;
    flush        = 1'b0;
    rdy_ok       = 1'b0;

    // Reset state.
    #12;
    check_bit("rst_ftch_vld", ftch_vld, 1'b0);
    check_bit("rst_mem_ftch_rdy", mem_ftch_rdy, 1'b0);
    check_val("rst_count", PKT_W'(count), '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);   // ready still low until this edge
    check_bit("rdy_after_release", mem_ftch_rdy, 1'b1);

    // Fill A..D with consumer stalled, then E must be refused.
    cycle(1'b1, 32'h0000_00A0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00B0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00C0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00D0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00E0, 1'b0, 1'b0);
    check_val("fill_count", PKT_W'(count), PKT_W'(DEPTH));
    check_bit("fill_rdy_low", mem_ftch_rdy, 1'b0);

    // Drain four packets in order.
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("drain_count", PKT_W'(count), '0);
    check_bit("drain_vld_low", ftch_vld, 1'b0);

    // Streaming across pointer wrap with occupancy steady at 1.
    cycle(1'b1, 32'h0000_1000, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      cycle(1'b1, 32'h0000_1000 + PKT_W'(i), 1'b1, 1'b0);
      check_val("wrap_count", PKT_W'(count), PKT_W'(1));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Full with a pop and a refused push, then push+pop at DEPTH-1.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0000_2000 + PKT_W'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_2FFF, 1'b1, 1'b0);
    check_val("full_pop_count", PKT_W'(count), PKT_W'(DEPTH - 1));
    cycle(1'b1, 32'h0000_2004, 1'b1, 1'b0);
    check_val("dm1_count", PKT_W'(count), PKT_W'(DEPTH - 1));

    // Flush at count 3 with a simultaneous push.
    cycle(1'b1, 32'h0000_3BAD, 1'b0, 1'b1);
    check_val("flush_count", PKT_W'(count), '0);
    check_bit("flush_vld", ftch_vld, 1'b0);
    check_bit("flush_rdy", mem_ftch_rdy, 1'b1);
    cycle(1'b1, 32'h0000_3001, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);   // must show 3001, not the flushed packet

`ifdef MEM_FTCH_QUEUE_BYPASS_EN
    // Same-cycle pass-through on an empty queue.
    cycle(1'b0, '0, 1'b0, 1'b0);
    mem_ftch_vld = 1'b1;
    mem_ftch_pkt = 32'h0000_DEAD;
    ftch_rdy     = 1'b1;
    #1;
    check_val("bypass_pkt", ftch_pkt, 32'h0000_DEAD);
    check_bit("bypass_vld", ftch_vld, 1'b1);
    @(posedge clk);
    #1;
    mem_ftch_vld = 1'b0;
    #1;
    check_val("bypass_count", PKT_W'(count), '0);
    @(posedge clk);
    #1;
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), PKT_W'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    // Reset asserted mid-stream.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_4001, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_4002, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check_bit("midrst_vld", ftch_vld, 1'b0);
    check_bit("midrst_rdy", mem_ftch_rdy, 1'b0);
    check_val("midrst_count", PKT_W'(count), '0);
    exp_q.delete();
    rdy_ok = 1'b0;
    mem_ftch_vld = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_5005, 1'b0, 1'b0);
    check_bit("post_rst_vld", ftch_vld, 1'b1);
    check_val("post_rst_pkt", ftch_pkt, 32'h0000_5005);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ftch_queue.md
MEM_FTCH_QUEUE -- requirements
Module: mem_ftch_queue

Interface
REQ-001 SHALL expose parameter DEPTH, default 4, number of buffered packets (power of two, >= 2).
REQ-002 SHALL expose parameter PKT_W, default $bits(mem_ftch_pkt_t), packet width in bits.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset, named clk and resetn.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 mem_ftch_vld  input  1  producer (memory stage) packet valid.
REQ-007 mem_ftch_pkt  input  PKT_W  producer packet.
REQ-008 mem_ftch_rdy  output  1  queue can accept a packet this cycle.
REQ-009 ftch_vld  output  1  consumer (fetch stage) packet valid.
REQ-010 ftch_pkt  output  PKT_W  consumer packet, head of queue.
REQ-011 ftch_rdy  input  1  consumer accepts packet this cycle.
REQ-012 flush  input  1  discard all buffered packets (redirect/branch).
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 Push SHALL occur when mem_ftch_vld && mem_ftch_rdy; pop SHALL occur when ftch_vld && ftch_rdy.
REQ-015 mem_ftch_rdy SHALL equal (count != DEPTH), driven from registered state only, with no combinational path from ftch_rdy.
REQ-016 ftch_vld SHALL equal (count != 0) when MEM_FTCH_QUEUE_BYPASS_EN is undefined; ftch_pkt SHALL be the oldest entry.
REQ-017 Push-to-ftch_vld latency SHALL be 1 cycle; order SHALL be strict FIFO.
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including at count==1 and count==DEPTH-1.
REQ-019 Full: mem_ftch_rdy low, so no push, even if a pop occurs in the same cycle.
REQ-020 Empty: ftch_vld low and ftch_pkt don't-care.
REQ-021 Read/write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow.
REQ-023 ftch_pkt SHALL stay stable while ftch_vld && !ftch_rdy.
REQ-024 flush SHALL set count and both pointers to 0 at the next edge, dropping any same-cycle push and pop; ftch_vld SHALL be 0 the cycle after flush.
REQ-025 mem_ftch_rdy SHALL be 1 the cycle after flush.

Reset
REQ-026 On resetn low, asynchronously: pointers 0, count 0, ftch_vld 0, mem_ftch_rdy 0.
REQ-027 mem_ftch_rdy SHALL rise on the first clk edge after resetn deasserts.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 Reset asserted mid-traffic SHALL discard all packets with no partial pop.

Configuration
REQ-030 Macro MEM_FTCH_QUEUE_BYPASS_EN defined: when count==0 and mem_ftch_vld, ftch_vld=1 and ftch_pkt=mem_ftch_pkt in the same cycle.
REQ-031 In that bypass case, if ftch_rdy=1 the packet SHALL NOT be written and count stays 0; otherwise it SHALL be written normally.
REQ-032 Bypass SHALL be suppressed while flush=1.
REQ-033 Macro undefined: no combinational path from the input side to the output side; latency per REQ-017.

Structure
REQ-034 mem_ftch_pkt_t and the default DEPTH constant SHALL live in mem_ftch_pkg.
REQ-035 Storage SHALL be a sub-module mem_ftch_queue_ram (DEPTH x PKT_W, 1 write port, 1 async read port).
REQ-036 Pointer, count, handshake and flush logic SHALL live in mem_ftch_queue.

Verification
REQ-037 Fill: DEPTH=4, ftch_rdy=0, push A,B,C,D -> count 4, mem_ftch_rdy 0, 5th packet E held and not accepted.
REQ-038 Drain: from full, ftch_rdy=1 for 4 cycles -> outputs A,B,C,D in order, count 0, ftch_vld 0.
REQ-039 Wrap: 10 packets through with push and pop every cycle after the first -> count steady at 1 and order preserved across pointer wrap.
REQ-040 Flush: count 3 with simultaneous push and flush -> next cycle count 0, ftch_vld 0, mem_ftch_rdy 1, pushed packet lost.
REQ-041 Reset: assert resetn low mid-stream -> ftch_vld and mem_ftch_rdy 0 immediately (asynchronous); after release, first push appears 1 cycle later.
REQ-042 Bypass (macro defined): empty queue, push 0xDEAD with ftch_rdy=1 -> ftch_pkt 0xDEAD in the same cycle and count stays 0.
